// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the FP32 divider issue stage
package fp_div_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int EXP_BIAS   = 127;

  localparam logic [DATA_WIDTH-1:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  // Sign is irrelevant to class; denormals count as zero (flush-to-zero).
  function automatic fp_class_t fp_classify(input logic [DATA_WIDTH-2:0] x);
    fp_class_t c;
    c.zero = (x[MANT_WIDTH +: EXP_WIDTH] == '0);
    c.inf  = (x[MANT_WIDTH +: EXP_WIDTH] == '1) && (x[MANT_WIDTH-1:0] == '0);
    c.nan  = (x[MANT_WIDTH +: EXP_WIDTH] == '1) && (x[MANT_WIDTH-1:0] != '0);
    c.snan = c.nan && !x[MANT_WIDTH-1];
    return c;
  endfunction

endpackage

// File: rtl/fp_div_ctrl_if.sv
// rtl/fp_div_ctrl_if.sv - operand, divider and writeback signals of the divider issue stage
interface fp_div_ctrl_if;
  import fp_div_pkg::*;

  logic                  in_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] in_numA;
  logic [DATA_WIDTH-1:0] in_numB;
  logic                  in_flush;
  logic [DATA_WIDTH-1:0] out_div_numA;
  logic [DATA_WIDTH-1:0] out_div_numB;
  logic                  out_div_start;
  logic                  in_div_stall;
  logic [DATA_WIDTH-1:0] in_div_result;
  logic                  out_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [4:0]            out_fflags;

  modport slave (
    input  in_valid, in_numA, in_numB, in_flush, in_div_stall, in_div_result, in_ready,
    output out_ready, out_div_numA, out_div_numB, out_div_start, out_valid, out_result, out_fflags
  );

  modport master (
    output in_valid, in_numA, in_numB, in_flush, in_div_stall, in_div_result, in_ready,
    input  out_ready, out_div_numA, out_div_numB, out_div_start, out_valid, out_result, out_fflags
  );

endinterface

// File: rtl/fp_div_classify.sv
// rtl/fp_div_classify.sv - special-operand and range bypass decision for FP32 division
// Flag outputs are live only when FP_DIV_FLAGS_EN is defined; otherwise they read zero.
module fp_div_classify
  import fp_div_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] num_a,
  input  logic [DATA_WIDTH-1:0] num_b,
  output logic                  bypass,
  output logic [DATA_WIDTH-1:0] value,
  output logic [4:0]            flags
);

`ifdef FP_DIV_FLAGS_EN
  localparam logic [4:0] FLAG_MASK = 5'h1F;
`else
  localparam logic [4:0] FLAG_MASK = 5'h00;
`endif

  fp_class_t             ca;
  fp_class_t             cb;
  logic                  sign;
  logic signed [9:0]     exp_q;
  logic [DATA_WIDTH-1:0] inf_s;
  logic [DATA_WIDTH-1:0] zero_s;
  logic [4:0]            flags_raw;

  assign ca     = fp_classify(num_a[DATA_WIDTH-2:0]);
  assign cb     = fp_classify(num_b[DATA_WIDTH-2:0]);
  assign sign   = num_a[DATA_WIDTH-1] ^ num_b[DATA_WIDTH-1];
  assign exp_q  = $signed({2'b00, num_a[MANT_WIDTH +: EXP_WIDTH]})
                - $signed({2'b00, num_b[MANT_WIDTH +: EXP_WIDTH]}) + 10'sd127;
  assign inf_s  = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  assign zero_s = {sign, {(DATA_WIDTH-1){1'b0}}};
  assign flags  = flags_raw & FLAG_MASK;

  always_comb begin
    bypass    = 1'b1;
    value     = CANON_NAN;
    flags_raw = '0;
    if (ca.nan || cb.nan) begin
      flags_raw[FLAG_NV] = ca.snan || cb.snan;
    end else if ((ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
      flags_raw[FLAG_NV] = 1'b1;
    end else if (ca.inf) begin
      value = inf_s;
    end else if (cb.zero) begin
      value              = inf_s;
      flags_raw[FLAG_DZ] = 1'b1;
    end else if (ca.zero || cb.inf) begin
      value = zero_s;
    end else if (exp_q >= 10'sd255) begin
      value              = inf_s;
      flags_raw[FLAG_OF] = 1'b1;
      flags_raw[FLAG_NX] = 1'b1;
    // e==1 with a smaller dividend mantissa normalises down to exponent 0
    end else if (exp_q <= 10'sd0 ||
                 (exp_q == 10'sd1 && num_a[MANT_WIDTH-1:0] < num_b[MANT_WIDTH-1:0])) begin
      value              = zero_s;
      flags_raw[FLAG_UF] = 1'b1;
      flags_raw[FLAG_NX] = 1'b1;
    end else begin
      bypass = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_ctrl.sv
// rtl/fp_div_ctrl.sv - FP32 divide issue stage: accept, bypass specials, launch divider, hold result
// Optional fflags reporting is enabled by defining FP_DIV_FLAGS_EN.
module fp_div_ctrl
  import fp_div_pkg::*;
(
  input  logic         in_Clk,
  input  logic         in_Rst_N,
  fp_div_ctrl_if.slave bus
);

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result_q;
  logic [4:0]            fflags_q;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] bypass_value;
  logic [4:0]            bypass_flags;
  logic                  accept;

  // Classification runs on the registered operands during LAUNCH.
  fp_div_classify u_classify (
    .num_a  (op_a),
    .num_b  (op_b),
    .bypass (bypass),
    .value  (bypass_value),
    .flags  (bypass_flags)
  );

  assign accept = bus.in_valid && (state == IDLE) && !bus.in_flush;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LAUNCH;
      LAUNCH:  if (bus.in_flush) state_nx = IDLE;
               else if (bypass) state_nx = DONE;
               else state_nx = WAIT;
      WAIT:    if (bus.in_flush) state_nx = DRAIN;
               else if (!bus.in_div_stall) state_nx = DONE;
      DRAIN:   if (!bus.in_div_stall) state_nx = IDLE;
      DONE:    if (bus.in_flush || bus.in_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a <= bus.in_numA;
        op_b <= bus.in_numB;
      end
      if (state == LAUNCH && !bus.in_flush && bypass) begin
        result_q <= bypass_value;
        fflags_q <= bypass_flags;
      end else if (state == WAIT && !bus.in_flush && !bus.in_div_stall) begin
        result_q <= bus.in_div_result;
        fflags_q <= '0;
      end
    end
  end

  assign bus.out_ready     = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.out_div_start = (state == LAUNCH) && !bypass && !bus.in_flush;
  assign bus.out_div_numA  = op_a;
  assign bus.out_div_numB  = op_b;
  assign bus.out_result    = result_q;
  assign bus.out_fflags    = fflags_q;

endmodule
